// File: rtl/zap_decode_issue_ctrl.sv
// Decode-stage issue controller: single-entry instruction holding register that
// injects an interrupt NOP (MOV R0,R0) at instruction boundaries toward the LDM/STM sequencer.
module zap_decode_issue_ctrl (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [31:0] i_instruction,
   input  logic        i_instruction_valid,
   input  logic        i_irq,
   input  logic        i_fiq,
   input  logic        i_irq_mask,
   input  logic        i_fiq_mask,
   input  logic        i_seq_stall,
   input  logic        i_clear_from_writeback,
   input  logic        i_data_stall,
   input  logic        i_clear_from_alu,
   input  logic        i_issue_stall,
   output logic [31:0] o_instruction,
   output logic        o_instruction_valid,
   output logic        o_irq,
   output logic        o_fiq,
   output logic        o_stall_to_fetch
);

   localparam logic [1:0]  IDLE = 2'd0;
   localparam logic [1:0]  HOLD = 2'd1;
   localparam logic [1:0]  INT  = 2'd2;
   localparam logic [31:0] NOP  = 32'hE1A00000;

   logic [1:0]  state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        irq_q, irq_d;
   logic        fiq_q, fiq_d;

   logic hold_valid, pstall, consume, free, boundary, fiq_req, irq_req;

   // The valid flag doubles as the hold-register occupancy (the NOP counts as held in INT).
   assign hold_valid = valid_q;
   assign pstall     = i_data_stall | i_issue_stall;
   assign consume    = hold_valid & ~i_seq_stall & ~pstall;
   assign free       = ~hold_valid | consume;
   assign fiq_req    = i_fiq & ~i_fiq_mask;
   assign irq_req    = i_irq & ~i_irq_mask;
   assign boundary   = free & (state_q != INT) & ~pstall;

   assign o_stall_to_fetch = (state_q == INT) | (hold_valid & ~consume);

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      valid_d = valid_q;
      irq_d   = irq_q;
      fiq_d   = fiq_q;
      if (i_clear_from_writeback) begin
         state_d = IDLE;
         valid_d = 1'b0;
         irq_d   = 1'b0;
         fiq_d   = 1'b0;
      end else if (i_data_stall) begin
         // Data stall freezes everything, masking a same-cycle ALU clear.
      end else if (i_clear_from_alu) begin
         state_d = IDLE;
         valid_d = 1'b0;
         irq_d   = 1'b0;
         fiq_d   = 1'b0;
      end else if (boundary) begin
         if (fiq_req | irq_req) begin
            state_d = INT;
            instr_d = NOP;
            valid_d = 1'b1;
            fiq_d   = fiq_req;
            irq_d   = irq_req & ~fiq_req;
         end else if (i_instruction_valid) begin
            state_d = HOLD;
            instr_d = i_instruction;
            valid_d = 1'b1;
            irq_d   = 1'b0;
            fiq_d   = 1'b0;
         end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            irq_d   = 1'b0;
            fiq_d   = 1'b0;
         end
      end else if ((state_q == INT) && consume) begin
         // NOP taken; park in INT with nothing held until the pipeline flushes.
         valid_d = 1'b0;
         irq_d   = 1'b0;
         fiq_d   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
         irq_q   <= 1'b0;
         fiq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         irq_q   <= irq_d;
         fiq_q   <= fiq_d;
      end
   end

   assign o_instruction       = instr_q;
   assign o_instruction_valid = valid_q;
   assign o_irq               = irq_q;
   assign o_fiq               = fiq_q;

endmodule

// File: tb/tb_zap_decode_issue_ctrl.sv
// Scoreboard bench for zap_decode_issue_ctrl: directed scenarios followed by random traffic.
module tb_zap_decode_issue_ctrl;

   localparam logic [31:0] NOP = 32'hE1A00000;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic [31:0] i_instruction;
   logic        i_instruction_valid;
   logic        i_irq, i_fiq, i_irq_mask, i_fiq_mask;
   logic        i_seq_stall, i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_issue_stall;
   logic [31:0] o_instruction;
   logic        o_instruction_valid, o_irq, o_fiq, o_stall_to_fetch;

   zap_decode_issue_ctrl dut (
      .i_clk                  (i_clk),
      .i_reset_n              (i_reset_n),
      .i_instruction          (i_instruction),
      .i_instruction_valid    (i_instruction_valid),
      .i_irq                  (i_irq),
      .i_fiq                  (i_fiq),
      .i_irq_mask             (i_irq_mask),
      .i_fiq_mask             (i_fiq_mask),
      .i_seq_stall            (i_seq_stall),
      .i_clear_from_writeback (i_clear_from_writeback),
      .i_data_stall           (i_data_stall),
      .i_clear_from_alu       (i_clear_from_alu),
      .i_issue_stall          (i_issue_stall),
      .o_instruction          (o_instruction),
      .o_instruction_valid    (o_instruction_valid),
      .o_irq                  (o_irq),
      .o_fiq                  (o_fiq),
      .o_stall_to_fetch       (o_stall_to_fetch)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] instr;
      logic        vld;
      logic        irq;
      logic        fiq;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic        m_int;
   logic        m_vld, m_irq, m_fiq;
   logic [31:0] m_ins;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_int = 1'b0;
      m_vld = 1'b0;
      m_irq = 1'b0;
      m_fiq = 1'b0;
      m_ins = 32'd0;
      exp_q.delete();
   endtask

   task automatic quiet();
      i_instruction = 32'd0; i_instruction_valid = 1'b0;
      i_irq = 1'b0; i_fiq = 1'b0; i_irq_mask = 1'b0; i_fiq_mask = 1'b0;
      i_seq_stall = 1'b0; i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;
      i_clear_from_alu = 1'b0; i_issue_stall = 1'b0;
   endtask

   // Called at a falling edge with inputs already driven; advances one clock.
   task automatic cyc();
      exp_t e;
      logic took, room, want_fiq, want_irq, exp_stall;
      #1;
      took      = m_vld && !i_seq_stall && !i_data_stall && !i_issue_stall;
      room      = !m_vld || took;
      exp_stall = m_int || (m_vld && !took);
      chk("stall_to_fetch", {31'd0, o_stall_to_fetch}, {31'd0, exp_stall});
      want_fiq = i_fiq && !i_fiq_mask;
      want_irq = i_irq && !i_irq_mask;
      if (i_clear_from_writeback || (!i_data_stall && i_clear_from_alu)) begin
         m_int = 1'b0; m_vld = 1'b0; m_irq = 1'b0; m_fiq = 1'b0;
      end else if (i_data_stall || i_issue_stall) begin
         // frozen
      end else if (room && !m_int) begin
         if (want_fiq || want_irq) begin
            m_int = 1'b1; m_ins = NOP; m_vld = 1'b1;
            m_fiq = want_fiq; m_irq = want_irq && !want_fiq;
         end else begin
            m_vld = i_instruction_valid; m_irq = 1'b0; m_fiq = 1'b0;
            if (i_instruction_valid) m_ins = i_instruction;
         end
      end else if (m_int && took) begin
         m_vld = 1'b0; m_irq = 1'b0; m_fiq = 1'b0;
      end
      e.instr = m_ins; e.vld = m_vld; e.irq = m_irq; e.fiq = m_fiq;
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      chk("valid", {31'd0, o_instruction_valid}, {31'd0, e.vld});
      if (e.vld) chk("instruction", o_instruction, e.instr);
      chk("irq", {31'd0, o_irq}, {31'd0, e.irq});
      chk("fiq", {31'd0, o_fiq}, {31'd0, e.fiq});
      @(negedge i_clk);
   endtask

   initial begin
      quiet();
      model_reset();
      i_reset_n = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("rst_instr", o_instruction, 32'd0);
      chk("rst_valid", {31'd0, o_instruction_valid}, 32'd0);
      chk("rst_irq_fiq", {30'd0, o_irq, o_fiq}, 32'd0);
      chk("rst_stall", {31'd0, o_stall_to_fetch}, 32'd0);
      i_reset_n = 1'b1;
      @(negedge i_clk);

      // Straight capture after reset
      i_instruction = 32'hE0811002; i_instruction_valid = 1'b1;
      cyc();
      chk("cap_instr", o_instruction, 32'hE0811002);
      chk("cap_stall", {31'd0, o_stall_to_fetch}, 32'd0);

      // LDM held by the sequencer, IRQ pending but not injected until it finishes
      i_instruction = 32'hE8BD000F;
      cyc();
      i_seq_stall = 1'b1; i_irq = 1'b1; i_instruction = 32'hE2811001;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("ldm_no_irq", {31'd0, o_irq}, 32'd0);
         chk("ldm_held", o_instruction, 32'hE8BD000F);
      end
      i_seq_stall = 1'b0;
      cyc();
      chk("ldm_nop", o_instruction, NOP);
      chk("ldm_nop_irq", {31'd0, o_irq}, 32'd1);
      i_irq = 1'b0;
      cyc();
      chk("int_stall", {31'd0, o_stall_to_fetch}, 32'd1);
      i_clear_from_writeback = 1'b1;
      cyc();
      i_clear_from_writeback = 1'b0;

      // Simultaneous FIQ and IRQ: FIQ wins, then park in INT until writeback clear
      i_irq = 1'b1; i_fiq = 1'b1;
      cyc();
      chk("fiq_prio", {30'd0, o_fiq, o_irq}, 32'd2);
      i_irq = 1'b0; i_fiq = 1'b0;
      cyc();
      cyc();
      chk("int_park_valid", {31'd0, o_instruction_valid}, 32'd0);
      i_clear_from_writeback = 1'b1;
      cyc();
      i_clear_from_writeback = 1'b0;

      // Masked FIQ does not disturb normal capture
      i_fiq = 1'b1; i_fiq_mask = 1'b1; i_instruction = 32'hE3A01005;
      cyc();
      chk("masked_fiq", {31'd0, o_fiq}, 32'd0);
      i_fiq = 1'b0; i_fiq_mask = 1'b0;

      // Data stall overrides an ALU clear; ALU clear alone then flushes
      i_seq_stall = 1'b1; i_data_stall = 1'b1; i_clear_from_alu = 1'b1; i_instruction = 32'hE1A02003;
      cyc();
      chk("dstall_hold", o_instruction, 32'hE3A01005);
      i_seq_stall = 1'b0; i_data_stall = 1'b0;
      cyc();
      chk("alu_clear", {31'd0, o_instruction_valid}, 32'd0);
      i_clear_from_alu = 1'b0;

      // Asynchronous reset while in INT
      i_instruction_valid = 1'b0; i_irq = 1'b1;
      cyc();
      i_irq = 1'b0;
      cyc();
      #2 i_reset_n = 1'b0;
      #1;
      chk("arst_instr", o_instruction, 32'd0);
      chk("arst_flags", {29'd0, o_instruction_valid, o_irq, o_fiq}, 32'd0);
      chk("arst_stall", {31'd0, o_stall_to_fetch}, 32'd0);
      model_reset();
      @(negedge i_clk);
      i_reset_n = 1'b1;
      i_instruction = 32'hE0422003; i_instruction_valid = 1'b1;
      cyc();
      chk("post_rst_cap", o_instruction, 32'hE0422003);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         i_instruction          = $urandom;
         i_instruction_valid    = ($urandom_range(0, 3) != 0);
         i_irq                  = ($urandom_range(0, 9) == 0);
         i_fiq                  = ($urandom_range(0, 14) == 0);
         i_irq_mask             = ($urandom_range(0, 3) == 0);
         i_fiq_mask             = ($urandom_range(0, 3) == 0);
         i_seq_stall            = ($urandom_range(0, 3) == 0);
         i_clear_from_writeback = ($urandom_range(0, 19) == 0);
         i_data_stall           = ($urandom_range(0, 7) == 0);
         i_clear_from_alu       = ($urandom_range(0, 14) == 0);
         i_issue_stall          = ($urandom_range(0, 7) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/zap_decode_issue_ctrl.md
ZAP_DECODE_ISSUE_CTRL -- requirements
Module: zap_decode_issue_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports i_clk and i_reset_n.
REQ-002 i_clk  in  1  ZAP clock; all state on rising edge.
REQ-003 i_reset_n  in  1  asynchronous active-low reset.
REQ-004 i_instruction  in  32  instruction from fetch.
REQ-005 i_instruction_valid  in  1  fetch instruction valid.
REQ-006 i_irq, i_fiq  in  1 each  level interrupt requests.
REQ-007 i_irq_mask, i_fiq_mask  in  1 each  CPSR I/F bits; 1 = masked.
REQ-008 i_seq_stall  in  1  LDM/STM sequencer busy (its stall output); input to it must stay stable while high.
REQ-009 i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_issue_stall  in  1 each  pipeline controls.
REQ-010 o_instruction  out  32  registered instruction to the sequencer.
REQ-011 o_instruction_valid  out  1  registered valid to the sequencer.
REQ-012 o_irq, o_fiq  out  1 each  registered interrupt tags to the sequencer.
REQ-013 o_stall_to_fetch  out  1  combinational; fetch holds i_instruction while high.

Function
REQ-014 SHALL hold one instruction in a register (hold_valid, o_instruction); fetch-to-sequencer latency exactly 1 cycle.
REQ-015 States: IDLE (hold_valid=0), HOLD (hold_valid=1, normal instruction), INT (interrupt NOP issued, awaiting flush).
REQ-016 pstall = i_data_stall | i_issue_stall.
REQ-017 consume = hold_valid & !i_seq_stall & !pstall (held instruction or NOP taken by sequencer this cycle).
REQ-018 free = !hold_valid | consume.
REQ-019 o_stall_to_fetch = (state==INT) | (hold_valid & !consume).
REQ-020 fiq_req = i_fiq & !i_fiq_mask; irq_req = i_irq & !i_irq_mask; sampled each cycle, not latched.
REQ-021 Boundary = free & state!=INT & !pstall.
REQ-022 At boundary with fiq_req|irq_req: next cycle o_instruction=32'hE1A00000 (MOV R0,R0), o_instruction_valid=1, o_fiq=fiq_req, o_irq=irq_req & !fiq_req (FIQ priority, one tag only); state->INT; fetch instruction not accepted.
REQ-023 At boundary without interrupt and i_instruction_valid=1: capture i_instruction, valid=1, o_irq=o_fiq=0; state->HOLD.
REQ-024 At boundary without interrupt and i_instruction_valid=0: o_instruction_valid=0; state->IDLE.
REQ-025 When !free: all outputs and state SHALL hold unchanged.
REQ-026 INT: after NOP consumed, o_instruction_valid=0, o_irq=o_fiq=0; remain in INT until a clear; o_stall_to_fetch=1 throughout.
REQ-027 Edge priority: i_clear_from_writeback > i_data_stall > i_clear_from_alu > i_issue_stall.
REQ-028 Clear (writeback or ALU, when not overridden by higher priority): o_instruction_valid=0, o_irq=o_fiq=0, state->IDLE, held instruction discarded; o_instruction value don't-care.
REQ-029 i_data_stall=1 (no writeback clear): no state change, clear_from_alu ignored that cycle.
REQ-030 Interrupt deasserted before boundary SHALL NOT be injected; interrupt never injected while i_seq_stall=1 (LDM/STM not split by this block).
REQ-031 i_instruction_valid and interrupt simultaneous at boundary: interrupt wins; instruction re-presented by fetch after flush.

Reset
REQ-032 i_reset_n=0 SHALL immediately force state=IDLE, hold_valid=0, o_instruction=0, o_instruction_valid=0, o_irq=0, o_fiq=0; o_stall_to_fetch=0.
REQ-033 Reset mid-LDM or in INT SHALL abandon operation; first edge after release behaves as IDLE.

Verification
REQ-034 Reset release, fetch 32'hE0811002 valid -> next cycle o_instruction=E0811002, valid=1, o_stall_to_fetch=0 while i_seq_stall=0.
REQ-035 Hold LDM, i_seq_stall=1 for 4 cycles, i_irq=1 unmasked -> no injection, o_stall_to_fetch=1 for 4 cycles; cycle after stall drops o_instruction=E1A00000, o_irq=1.
REQ-036 i_irq=i_fiq=1, both unmasked, IDLE -> next cycle o_fiq=1, o_irq=0; state INT, valid=0 from following cycle until i_clear_from_writeback, then IDLE.
REQ-037 i_fiq=1, i_fiq_mask=1, i_irq=0, valid fetch -> normal capture, o_fiq=0.
REQ-038 i_data_stall=1 with i_clear_from_alu=1 in HOLD -> outputs unchanged; next cycle clear_from_alu alone -> valid=0, IDLE.
REQ-039 Assert i_reset_n=0 asynchronously mid-cycle in INT -> outputs zero before next clock edge.
